// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path.
// Holds the default line parameters, the FSM state encodings, the byte and
// strobe payload types, and the sample-tick divider calculation. The TX path
// uses the same divider calculation.
package uart_receiver_pkg;

  // Default line parameters
  localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
  localparam int unsigned DEF_BAUD       = 9600;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  // Frame geometry (8N1)
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  // Receiver FSM encodings, kept as plain constants for legacy compatibility
  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE      = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_START     = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_DATA      = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_STOP      = STATE_W'(3);
  localparam logic [STATE_W-1:0] ST_WAIT_HIGH = STATE_W'(4);

  typedef logic [DATA_W-1:0] rx_byte_t;

  // One-cycle event strobes presented to the register block
  typedef struct packed {
    logic valid;
    logic frame_err;
    logic overrun;
  } rx_strobe_t;

  // sysclk cycles per oversample tick (integer division, truncating)
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte/status bus between the UART receiver and the peripheral register block.
//  rx_data    receiver -> consumer  last good byte
//  rx_valid   receiver -> consumer  one-cycle pulse, new byte in rx_data
//  rx_pending receiver -> consumer  byte available, not yet acknowledged
//  rx_busy    receiver -> consumer  frame reception in progress
//  frame_err  receiver -> consumer  one-cycle pulse, stop bit sampled low
//  overrun    receiver -> consumer  one-cycle pulse, byte lost to overwrite
//  rx_ack     consumer -> receiver  consumer has read rx_data
interface uart_receiver_if;
  import uart_receiver_pkg::*;

  rx_byte_t rx_data;
  logic     rx_valid;
  logic     rx_pending;
  logic     rx_busy;
  logic     frame_err;
  logic     overrun;
  logic     rx_ack;

  // Receiver side
  modport master (
    output rx_data,
    output rx_valid,
    output rx_pending,
    output rx_busy,
    output frame_err,
    output overrun,
    input  rx_ack
  );

  // Consumer side
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_pending,
    input  rx_busy,
    input  frame_err,
    input  overrun,
    output rx_ack
  );

endinterface

// File: rtl/uart_sample_tick.sv
// Oversample tick generator: divides sysclk by DIV.
//  sysclk  in   system clock
//  reset   in   synchronous, active-high
//  hold    in   forces the divider to 0 and suppresses the tick
//  tick_c  out  high for one cycle when the divider reaches DIV-1
// Releasing hold starts a fresh count from 0, so the first tick lands DIV
// cycles after release; the receiver uses this to phase-align ticks to the
// start-bit falling edge.
module uart_sample_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic sysclk,
  input  logic reset,
  input  logic hold,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Divider counter: 0..DIV-1, cleared while held
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (hold || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_c = ~hold & (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first, with 16x (OVERSAMPLE) mid-bit sampling.
//  sysclk   in   system clock, all logic on posedge
//  reset    in   synchronous, active-high; wins over every other event
//  uart_rx  in   asynchronous serial line, idle high
//  rx_if    master side of the byte/status bus (rx_data, rx_valid,
//           rx_pending, rx_busy, frame_err, overrun out; rx_ack in)
// All outputs are registered. Strobes appear in the cycle after the tick
// that decides them. rx_valid rises about (OVERSAMPLE/2 + 9*OVERSAMPLE)*DIV + 4
// sysclk cycles after the falling edge of the start bit.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            uart_rx,
  uart_receiver_if.master rx_if
);

  localparam int unsigned DIV     = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned S_CNT_W = $clog2(OVERSAMPLE);

  localparam logic [S_CNT_W-1:0]   S_MID  = S_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_CNT_W-1:0]   S_LAST = S_CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0] B_LAST = BIT_CNT_W'(DATA_W - 1);

  // Synchronizer
  logic s1_q;
  logic rx_s_q;

  // FSM and datapath state
  logic [STATE_W-1:0]   state_q,   state_nxt;
  logic [S_CNT_W-1:0]   s_cnt_q,   s_cnt_nxt;
  logic [BIT_CNT_W-1:0] b_cnt_q,   b_cnt_nxt;
  rx_byte_t             shift_q,   shift_nxt;

  // Output registers
  rx_byte_t             data_q,    data_nxt;
  rx_strobe_t           strobe_q,  strobe_nxt;
  logic                 pending_q, pending_nxt;
  logic                 busy_q,    busy_nxt;

  logic tick_c;
  logic tick_hold_c;

  // Two-flop re-timing of the asynchronous line; idles high out of reset
  always_ff @(posedge sysclk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      s1_q   <= uart_rx;
      rx_s_q <= s1_q;
    end
  end

  // Ticks only run while a frame is being timed; the IDLE->START transition
  // releases the divider so ticks are phase-aligned to the falling edge.
  assign tick_hold_c = (state_q == ST_IDLE) || (state_q == ST_WAIT_HIGH);

  uart_sample_tick #(
    .DIV (DIV)
  ) u_sample_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .hold   (tick_hold_c),
    .tick_c (tick_c)
  );

  // State and output registers
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_cnt_q   <= '0;
      b_cnt_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      strobe_q  <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      s_cnt_q   <= s_cnt_nxt;
      b_cnt_q   <= b_cnt_nxt;
      shift_q   <= shift_nxt;
      data_q    <= data_nxt;
      strobe_q  <= strobe_nxt;
      pending_q <= pending_nxt;
      busy_q    <= busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state_q;
    s_cnt_nxt   = s_cnt_q;
    b_cnt_nxt   = b_cnt_q;
    shift_nxt   = shift_q;
    data_nxt    = data_q;
    strobe_nxt  = '0;
    pending_nxt = pending_q;

    // Acknowledge clears; a completing frame below sets and takes priority
    if (rx_if.rx_ack) begin
      pending_nxt = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_nxt = ST_START;
          s_cnt_nxt = '0;
        end
      end

      ST_START: begin
        if (tick_c) begin
          if (s_cnt_q == S_MID) begin
            // Mid start bit: a line already back high was a glitch
            if (rx_s_q) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DATA;
              s_cnt_nxt = '0;
              b_cnt_nxt = '0;
            end
          end else begin
            s_cnt_nxt = s_cnt_q + S_CNT_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick_c) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_nxt = '0;
            shift_nxt = {rx_s_q, shift_q[DATA_W-1:1]};
            if (b_cnt_q == B_LAST) begin
              state_nxt = ST_STOP;
            end else begin
              b_cnt_nxt = b_cnt_q + BIT_CNT_W'(1);
            end
          end else begin
            s_cnt_nxt = s_cnt_q + S_CNT_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (tick_c) begin
          if (s_cnt_q == S_LAST) begin
            // Mid stop bit: returning to IDLE here catches a start bit
            // that follows the stop bit directly.
            if (rx_s_q) begin
              data_nxt           = shift_q;
              strobe_nxt.valid   = 1'b1;
              strobe_nxt.overrun = pending_q & ~rx_if.rx_ack;
              pending_nxt        = 1'b1;
              state_nxt          = ST_IDLE;
            end else begin
              strobe_nxt.frame_err = 1'b1;
              state_nxt            = ST_WAIT_HIGH;
            end
          end else begin
            s_cnt_nxt = s_cnt_q + S_CNT_W'(1);
          end
        end
      end

      ST_WAIT_HIGH: begin
        // A held-low line (break) is not read as a stream of new frames
        if (rx_s_q) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = strobe_q.valid;
  assign rx_if.frame_err  = strobe_q.frame_err;
  assign rx_if.overrun    = strobe_q.overrun;
  assign rx_if.rx_pending = pending_q;
  assign rx_if.rx_busy    = busy_q;

endmodule
